// File: rtl/mem_addr_seq_if.sv
// Request/address bus between an access initiator and the address sequencer.
// Carries source selection, access request and memory-side strobes/status.
interface mem_addr_seq_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 6,
   parameter int SELW  = 3
);
   logic [SELW-1:0]       sel;
   logic [NSRC*WIDTH-1:0] src;
   logic [1:0]            size;
   logic                  req;
   logic                  we;
   logic                  clr_exc;
   logic [WIDTH-1:0]      addr;
   logic                  mem_en;
   logic                  mem_we;
   logic                  busy;
   logic                  done;
   logic                  misalign;

   modport master (
      output sel, src, size, req, we, clr_exc,
      input  addr, mem_en, mem_we, busy, done, misalign
   );

   modport slave (
      input  sel, src, size, req, we, clr_exc,
      output addr, mem_en, mem_we, busy, done, misalign
   );
endinterface

// File: rtl/mem_addr_seq.sv
// Address sequencer: selects a source address, checks alignment, drives mem_en for LAT cycles.
// Latency: accept edge -> LAT access cycles -> done in next IDLE cycle; req while busy is dropped.
module mem_addr_seq #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 6,
   parameter int SELW  = 3,
   parameter int LAT   = 2
) (
   input logic           clk,
   input logic           reset_n,
   mem_addr_seq_if.slave bus
);
   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_EXC    = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_addr, w_addr_nxt;
   logic             r_mem_en, w_mem_en_nxt;
   logic             r_mem_we, w_mem_we_nxt;
   logic             r_done, w_done_nxt;
   logic             r_misalign;
   logic             w_mis_set;
   logic [WIDTH-1:0] w_sel_val;
   logic             w_aligned;

   // Out-of-range selects fall through to an all-zero address.
   always_comb begin
      w_sel_val = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (bus.sel == SELW'(k)) begin
            w_sel_val = bus.src[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_aligned = 1'b1;
      case (bus.size)
         2'b00:   w_aligned = 1'b1;
         2'b01:   w_aligned = ~w_sel_val[0];
         default: w_aligned = (w_sel_val[1:0] == 2'b00);
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_addr_nxt   = r_addr;
      w_mem_en_nxt = r_mem_en;
      w_mem_we_nxt = r_mem_we;
      w_done_nxt   = 1'b0;
      w_mis_set    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req) begin
               w_addr_nxt = w_sel_val;
               if (w_aligned) begin
                  w_state_nxt  = S_ACCESS;
                  w_cnt_nxt    = CW'(LAT - 1);
                  w_mem_en_nxt = 1'b1;
                  w_mem_we_nxt = bus.we;
               end else begin
                  w_state_nxt = S_EXC;
                  w_mis_set   = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            if (r_cnt == '0) begin
               w_state_nxt  = S_IDLE;
               w_mem_en_nxt = 1'b0;
               w_mem_we_nxt = 1'b0;
               w_done_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         // Re-asserting the set here lets it win over a clear issued during EXC.
         S_EXC: begin
            w_state_nxt = S_IDLE;
            w_mis_set   = 1'b1;
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_mem_en_nxt = 1'b0;
            w_mem_we_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_addr   <= w_addr_nxt;
         r_mem_en <= w_mem_en_nxt;
         r_mem_we <= w_mem_we_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_misalign <= 1'b0;
      end else if (w_mis_set) begin
         r_misalign <= 1'b1;
      end else if (bus.clr_exc) begin
         r_misalign <= 1'b0;
      end
   end

   assign bus.addr     = r_addr;
   assign bus.mem_en   = r_mem_en;
   assign bus.mem_we   = r_mem_we;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;
   assign bus.misalign = r_misalign;
endmodule

// File: tb/tb_mem_addr_seq.sv
// Directed bench for mem_addr_seq with hand-computed expectations (WIDTH=32, NSRC=6, SELW=3, LAT=2).
module tb_mem_addr_seq;
   logic clk;
   logic reset_n;
   int   n_pass;
   int   n_total;
   int   done_cnt;

   mem_addr_seq_if #(.WIDTH(32), .NSRC(6), .SELW(3)) bus ();

   mem_addr_seq #(.WIDTH(32), .NSRC(6), .SELW(3), .LAT(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance one clock; sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cnt++;
   endtask

   initial begin
      n_pass      = 0;
      n_total     = 0;
      done_cnt    = 0;
      reset_n     = 1'b0;
      bus.sel     = '0;
      bus.src     = '0;
      bus.size    = 2'b00;
      bus.req     = 1'b0;
      bus.we      = 1'b0;
      bus.clr_exc = 1'b0;
      #1;
      chk32("rst_addr", bus.addr, 32'h0);
      chk1("rst_mem_en", bus.mem_en, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_misalign", bus.misalign, 1'b0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Aligned word read from source 2
      bus.src[2*32 +: 32] = 32'h0000_1004;
      bus.src[1*32 +: 32] = 32'h0000_2003;
      bus.src[0*32 +: 32] = 32'h0000_0100;
      bus.src[3*32 +: 32] = 32'h0000_0200;
      bus.src[4*32 +: 32] = 32'h0000_3001;
      bus.src[5*32 +: 32] = 32'h0000_3002;
      bus.sel  = 3'd2;
      bus.size = 2'b10;
      bus.we   = 1'b0;
      bus.req  = 1'b1;
      tick();
      bus.req = 1'b0;
      chk32("rd_addr", bus.addr, 32'h0000_1004);
      chk1("rd_busy", bus.busy, 1'b1);
      chk1("rd_en_c1", bus.mem_en, 1'b1);
      chk1("rd_we", bus.mem_we, 1'b0);
      chk1("rd_done_c1", bus.done, 1'b0);
      tick();
      chk1("rd_en_c2", bus.mem_en, 1'b1);
      chk1("rd_done_c2", bus.done, 1'b0);
      tick();
      chk1("rd_done", bus.done, 1'b1);
      chk1("rd_en_off", bus.mem_en, 1'b0);
      chk1("rd_busy_off", bus.busy, 1'b0);
      chk1("rd_misalign", bus.misalign, 1'b0);
      tick();
      chk1("rd_done_pulse", bus.done, 1'b0);

      // Misaligned half write from source 1
      bus.sel  = 3'd1;
      bus.size = 2'b01;
      bus.we   = 1'b1;
      bus.req  = 1'b1;
      tick();
      bus.req = 1'b0;
      bus.we  = 1'b0;
      chk1("exc_busy", bus.busy, 1'b1);
      chk1("exc_en", bus.mem_en, 1'b0);
      chk1("exc_we", bus.mem_we, 1'b0);
      chk1("exc_misalign", bus.misalign, 1'b1);
      chk32("exc_addr", bus.addr, 32'h0000_2003);
      tick();
      chk1("exc_idle", bus.busy, 1'b0);
      chk1("exc_no_done", bus.done, 1'b0);
      chk1("exc_en_after", bus.mem_en, 1'b0);
      chk32("exc_addr_hold", bus.addr, 32'h0000_2003);
      chk1("exc_sticky", bus.misalign, 1'b1);
      bus.clr_exc = 1'b1;
      tick();
      bus.clr_exc = 1'b0;
      chk1("exc_clr", bus.misalign, 1'b0);

      // Out-of-range select yields address zero and a normal access
      bus.sel  = 3'd7;
      bus.size = 2'b10;
      bus.req  = 1'b1;
      tick();
      bus.req = 1'b0;
      chk32("oor_addr", bus.addr, 32'h0);
      chk1("oor_en", bus.mem_en, 1'b1);
      tick();
      tick();
      chk1("oor_done", bus.done, 1'b1);
      chk1("oor_misalign", bus.misalign, 1'b0);

      // Back-to-back: req held through ACCESS, taken again in the done cycle
      done_cnt = 0;
      bus.sel  = 3'd0;
      bus.size = 2'b10;
      bus.req  = 1'b1;
      tick();
      chk32("b2b_addr1", bus.addr, 32'h0000_0100);
      bus.sel = 3'd3;
      tick();
      chk32("b2b_ignored", bus.addr, 32'h0000_0100);
      chk1("b2b_en_held", bus.mem_en, 1'b1);
      tick();
      chk1("b2b_done1", bus.done, 1'b1);
      chk32("b2b_addr_hold", bus.addr, 32'h0000_0100);
      tick();
      bus.req = 1'b0;
      chk32("b2b_addr2", bus.addr, 32'h0000_0200);
      chk1("b2b_en2", bus.mem_en, 1'b1);
      tick();
      tick();
      tick();
      tick();
      chk32("b2b_done_count", 32'(done_cnt), 32'd2);

      // Reset asserted in the first ACCESS cycle
      bus.sel  = 3'd2;
      bus.size = 2'b10;
      bus.we   = 1'b1;
      bus.req  = 1'b1;
      tick();
      bus.req = 1'b0;
      bus.we  = 1'b0;
      chk1("mid_en_pre", bus.mem_en, 1'b1);
      chk1("mid_we_pre", bus.mem_we, 1'b1);
      #1;
      reset_n = 1'b0;
      #1;
      chk32("mid_addr", bus.addr, 32'h0);
      chk1("mid_en", bus.mem_en, 1'b0);
      chk1("mid_we", bus.mem_we, 1'b0);
      chk1("mid_busy", bus.busy, 1'b0);
      chk1("mid_done", bus.done, 1'b0);
      chk1("mid_misalign", bus.misalign, 1'b0);
      tick();
      reset_n  = 1'b1;
      done_cnt = 0;
      tick();
      tick();
      tick();
      chk32("mid_no_done", 32'(done_cnt), 32'd0);
      bus.req = 1'b1;
      tick();
      bus.req = 1'b0;
      chk1("post_rst_accept", bus.busy, 1'b1);
      chk32("post_rst_addr", bus.addr, 32'h0000_1004);
      tick();
      tick();
      chk1("post_rst_done", bus.done, 1'b1);

      // Misaligned byte passes; aligned half passes
      bus.sel  = 3'd4;
      bus.size = 2'b00;
      bus.req  = 1'b1;
      tick();
      bus.req = 1'b0;
      chk1("byte_en", bus.mem_en, 1'b1);
      chk1("byte_misalign", bus.misalign, 1'b0);
      tick();
      tick();
      bus.sel  = 3'd5;
      bus.size = 2'b01;
      bus.req  = 1'b1;
      tick();
      bus.req = 1'b0;
      chk1("half_en", bus.mem_en, 1'b1);
      tick();
      tick();

      // Misaligned word with clr_exc on the EXC cycle: set wins
      bus.size = 2'b11;
      bus.req  = 1'b1;
      tick();
      bus.req     = 1'b0;
      bus.clr_exc = 1'b1;
      chk1("coll_exc_en", bus.mem_en, 1'b0);
      tick();
      bus.clr_exc = 1'b0;
      chk1("coll_set_wins", bus.misalign, 1'b1);

      // Request accepted while misalign is still set
      bus.sel  = 3'd0;
      bus.size = 2'b10;
      bus.req  = 1'b1;
      tick();
      bus.req = 1'b0;
      chk1("mis_accept_en", bus.mem_en, 1'b1);
      chk32("mis_accept_addr", bus.addr, 32'h0000_0100);
      chk1("mis_still_set", bus.misalign, 1'b1);
      tick();
      tick();
      chk1("mis_accept_done", bus.done, 1'b1);
      bus.clr_exc = 1'b1;
      tick();
      bus.clr_exc = 1'b0;
      chk1("final_clr", bus.misalign, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
